mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 128-bit line-wide main-memory port between the instruction cache (I) and data cache (D) in the pipelined MIPS core.
- Each cache sees a private memory interface with the same signal set as the memory itself: read, write, 28-bit line address, 128-bit wdata, 128-bit rdata, ready.
- The arbiter locks a grant for a whole memory transaction and routes ready/rdata back to the granted cache only.
- It sits between the two cache instances and the memory model at the top level.

Parameters:
- ADDR_W, 28, line address width.
- DATA_W, 128, line width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- i_mem_read  in  1  I-cache read request.
- i_mem_write  in  1  I-cache write request. Normally 0; forwarded anyway.
- i_mem_addr  in  ADDR_W  I-cache line address.
- i_mem_wdata  in  DATA_W  I-cache write data.
- i_mem_rdata  out  DATA_W  read data to I-cache.
- i_mem_ready  out  1  completion to I-cache.
- d_mem_read  in  1  D-cache read request.
- d_mem_write  in  1  D-cache write request (write-back).
- d_mem_addr  in  ADDR_W  D-cache line address.
- d_mem_wdata  in  DATA_W  D-cache write data.
- d_mem_rdata  out  DATA_W  read data to D-cache.
- d_mem_ready  out  1  completion to D-cache.
- mem_read  out  1  to memory.
- mem_write  out  1  to memory.
- mem_addr  out  ADDR_W  to memory.
- mem_wdata  out  DATA_W  to memory.
- mem_rdata  in  DATA_W  from memory.
- mem_ready  in  1  from memory; one-cycle completion pulse.
- gnt  out  2  current owner: 00 none, 01 I, 10 D.

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous, active-low.
  - State goes to IDLE. gnt=00.
  - All memory and requester outputs are combinationally 0 while rst_n=0.
- Request: req_i = i_mem_read|i_mem_write; req_d = d_mem_read|d_mem_write.
- States:
  - IDLE
    - Winner is chosen combinationally in the same cycle: D over I when both request (fixed priority).
    - The winner's read/write/addr/wdata drive memory in that same cycle, so the arbiter adds 0 cycles of latency.
    - Next state: OWN_I or OWN_D, unless mem_ready is already high in that cycle. In that case the transaction is complete and the state stays IDLE.
    - No request: memory outputs are 0 and the state stays IDLE.
  - OWN_I / OWN_D
    - Memory outputs are forwarded combinationally from the owner as-is.
    - The non-owner sees ready=0 and rdata=0 and keeps waiting (stalled).
    - On mem_ready=1: the owner receives ready=1 and rdata=mem_rdata in the same cycle, and the next state is IDLE.
    - The grant is held until mem_ready even if the owner drops its request. Memory then sees read=write=0.
- Re-arbitration happens only in IDLE, at least one cycle after the previous ready.
  - A D-cache write-back followed by a refill read is two separate transactions. I may win in between.
- Routing:
  - rdata to the non-owner is always 0.
  - mem_ready arriving in IDLE with no request is ignored.
- gnt reflects the combinational owner, including the IDLE same-cycle winner.
- Reset asserted mid-transaction: immediate return to IDLE and all outputs 0. The memory must be reset together with the arbiter.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register (reset value = I) selects priority.
  - When both request in IDLE, the requester that did not own the previous completed transaction wins.
  - last_owner updates on each completion.
- Undefined: fixed D-over-I priority, and no extra register.

Decomposition:
- Shared package: state encoding (IDLE=0, OWN_I=1, OWN_D=2), GNT_NONE/GNT_I/GNT_D constants, ADDR_W/DATA_W defaults.
- Natural sub-module: mem_arb_mux, a pure combinational owner-select mux for the memory outputs and the ready/rdata demux. The FSM stays in the top level.

Test Plan:
- Reset: rst_n=0 while d_mem_read=1 -> mem_read=0, gnt=00, both ready=0. Release -> mem_read=1 in the same cycle, mem_addr=d_mem_addr.
- I-only read:
  - Stimulus: i_mem_read=1, addr=0x0000010; memory returns ready after 4 cycles with rdata=0xDEADBEEF_...
  - Required: gnt=01 throughout; i_mem_ready pulses 1 cycle with that data; d_mem_ready=0; IDLE the next cycle.
- Simultaneous requests: I and D both read in IDLE -> D granted. I stalls until D's ready, then I is granted the following cycle.
  - With ARB_ROUND_ROBIN_EN and last_owner=D -> I granted first.
- D write-back then refill, with I requesting:
  - d_mem_write=1 addr=0x0000A3 -> memory sees the write.
  - After ready, D raises read while I is requesting -> fixed priority: D again; round-robin: I first.
- Owner drops request mid-grant: D granted, d_mem_read deasserted after 1 cycle -> gnt stays 10 and mem_read=0 until mem_ready. I is not granted before the following IDLE cycle.
- Async reset mid-transaction: pulse rst_n low between clock edges while gnt=01 -> all outputs 0 immediately; after release the state is IDLE, and any pending request is re-arbitrated.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_mux.sv
// Owner-select mux toward memory and ready/rdata demux back to the caches.
module mem_arb_mux
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        owner,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    always_comb begin
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        i_mem_rdata = '0;
        i_mem_ready = 1'b0;
        d_mem_rdata = '0;
        d_mem_ready = 1'b0;
        case (owner)
            GNT_I: begin
                mem_read    = i_mem_read;
                mem_write   = i_mem_write;
                mem_addr    = i_mem_addr;
                mem_wdata   = i_mem_wdata;
                i_mem_rdata = mem_rdata;
                i_mem_ready = mem_ready;
            end
            GNT_D: begin
                mem_read    = d_mem_read;
                mem_write   = d_mem_write;
                mem_addr    = d_mem_addr;
                mem_wdata   = d_mem_wdata;
                d_mem_rdata = mem_rdata;
                d_mem_ready = mem_ready;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// I/D cache arbiter for the shared line-wide memory port, grant locked per transaction.
// Build option ARB_ROUND_ROBIN_EN: alternate priority on contention instead of fixed D-over-I.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        gnt
);

    arb_state_t state_q, state_d;
    logic [1:0] owner_raw_c;
    logic [1:0] owner_c;
    logic       req_i, req_d;
    logic       d_first;

    assign req_i = i_mem_read | i_mem_write;
    assign req_d = d_mem_read | d_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;

    // Owner of the most recently completed transaction; I after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b0;
        end else if ((owner_raw_c != GNT_NONE) && mem_ready) begin
            last_d_q <= (owner_raw_c == GNT_D);
        end
    end

    assign d_first = ~last_d_q;
`else
    assign d_first = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner selection and next state; an IDLE winner completing immediately never leaves IDLE.
    always_comb begin
        owner_raw_c = GNT_NONE;
        state_d     = state_q;
        case (state_q)
            IDLE: begin
                if (req_d && (!req_i || d_first)) begin
                    owner_raw_c = GNT_D;
                end else if (req_i) begin
                    owner_raw_c = GNT_I;
                end
                if ((owner_raw_c != GNT_NONE) && !mem_ready) begin
                    state_d = (owner_raw_c == GNT_D) ? OWN_D : OWN_I;
                end
            end
            OWN_I: begin
                owner_raw_c = GNT_I;
                if (mem_ready) state_d = IDLE;
            end
            OWN_D: begin
                owner_raw_c = GNT_D;
                if (mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset silences every output immediately, independent of the clock.
    assign owner_c = rst_n ? owner_raw_c : GNT_NONE;
    assign gnt     = owner_c;

    mem_arb_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .owner      (owner_c),
        .i_mem_read (i_mem_read),
        .i_mem_write(i_mem_write),
        .i_mem_addr (i_mem_addr),
        .i_mem_wdata(i_mem_wdata),
        .i_mem_rdata(i_mem_rdata),
        .i_mem_ready(i_mem_ready),
        .d_mem_read (d_mem_read),
        .d_mem_write(d_mem_write),
        .d_mem_addr (d_mem_addr),
        .d_mem_wdata(d_mem_wdata),
        .d_mem_rdata(d_mem_rdata),
        .d_mem_ready(d_mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         i_mem_read, i_mem_write;
    logic [27:0]  i_mem_addr;
    logic [127:0] i_mem_wdata, i_mem_rdata;
    logic         i_mem_ready;
    logic         d_mem_read, d_mem_write;
    logic [27:0]  d_mem_addr;
    logic [127:0] d_mem_wdata, d_mem_rdata;
    logic         d_mem_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    logic [1:0]   gnt;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: who holds the port (0 none, 1 I, 2 D) and who finished last.
    int m_busy   = 0;
    bit m_last_d = 1'b0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_addr(i_mem_addr),
        .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_addr(d_mem_addr),
        .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .gnt(gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_i(input logic r, input logic w, input logic [27:0] a, input logic [127:0] wd);
        i_mem_read = r; i_mem_write = w; i_mem_addr = a; i_mem_wdata = wd;
    endtask

    task automatic set_d(input logic r, input logic w, input logic [27:0] a, input logic [127:0] wd);
        d_mem_read = r; d_mem_write = w; d_mem_addr = a; d_mem_wdata = wd;
    endtask

    function automatic int pick_owner(input bit ri, input bit rd);
        if (m_busy != 0) return m_busy;
        if (ri && rd) return (RR && m_last_d) ? 1 : 2;
        if (rd) return 2;
        if (ri) return 1;
        return 0;
    endfunction

    task automatic test_reset();
        logic [127:0] r;
        r = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        rst_n = 1'b0;
        set_i(0, 0, '0, '0);
        set_d(1, 0, 28'h0000055, '0);
        mem_ready = 1'b1;
        mem_rdata = r;
        #1;
        checks++;
        if (mem_read !== 1'b0 || gnt !== 2'b00)
            begin errors++; $display("FAIL reset_mem got read=%b gnt=%b exp read=0 gnt=00", mem_read, gnt); end
        checks++;
        if (d_mem_ready !== 1'b0 || i_mem_ready !== 1'b0 || d_mem_rdata !== '0)
            begin errors++; $display("FAIL reset_ready got d=%b i=%b drdata=%h exp 0 0 0", d_mem_ready, i_mem_ready, d_mem_rdata); end
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== 28'h0000055 || gnt !== 2'b10)
            begin errors++; $display("FAIL release_grant got read=%b addr=%h gnt=%b exp 1 0000055 10", mem_read, mem_addr, gnt); end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_mem_ready !== 1'b1 || d_mem_rdata !== r)
            begin errors++; $display("FAIL idle_complete got ready=%b rdata=%h exp 1 %h", d_mem_ready, d_mem_rdata, r); end
        @(negedge clk);
        set_d(0, 0, '0, '0);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00 || d_mem_ready !== 1'b0)
            begin errors++; $display("FAIL after_idle_complete got gnt=%b ready=%b exp 00 0", gnt, d_mem_ready); end
    endtask

    task automatic test_i_read();
        logic [127:0] r;
        r = 128'hDEADBEEF_01234567_89ABCDEF_0BADF00D;
        @(negedge clk);
        set_i(1, 0, 28'h0000010, '0);
        #1;
        checks++;
        if (gnt !== 2'b01 || mem_read !== 1'b1 || mem_addr !== 28'h0000010)
            begin errors++; $display("FAIL i_read_start got gnt=%b read=%b addr=%h exp 01 1 0000010", gnt, mem_read, mem_addr); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (gnt !== 2'b01 || i_mem_ready !== 1'b0)
                begin errors++; $display("FAIL i_read_wait%0d got gnt=%b ready=%b exp 01 0", k, gnt, i_mem_ready); end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = r;
        #1;
        checks++;
        if (gnt !== 2'b01 || i_mem_ready !== 1'b1 || i_mem_rdata !== r)
            begin errors++; $display("FAIL i_read_done got gnt=%b ready=%b rdata=%h exp 01 1 %h", gnt, i_mem_ready, i_mem_rdata, r); end
        checks++;
        if (d_mem_ready !== 1'b0 || d_mem_rdata !== '0)
            begin errors++; $display("FAIL i_read_d_quiet got ready=%b rdata=%h exp 0 0", d_mem_ready, d_mem_rdata); end
        @(negedge clk);
        set_i(0, 0, '0, '0);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00 || mem_read !== 1'b0)
            begin errors++; $display("FAIL i_read_idle got gnt=%b read=%b exp 00 0", gnt, mem_read); end
    endtask

    task automatic test_simultaneous();
        logic [127:0] r1, r2;
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        set_i(1, 0, 28'h0000020, '0);
        set_d(1, 0, 28'h0000030, '0);
        #1;
        checks++;
        if (gnt !== 2'b10 || mem_addr !== 28'h0000030)
            begin errors++; $display("FAIL simul_first got gnt=%b addr=%h exp 10 0000030", gnt, mem_addr); end
        @(negedge clk);
        #1;
        checks++;
        if (gnt !== 2'b10 || i_mem_ready !== 1'b0)
            begin errors++; $display("FAIL simul_i_stall got gnt=%b iready=%b exp 10 0", gnt, i_mem_ready); end
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = r1;
        #1;
        checks++;
        if (d_mem_ready !== 1'b1 || d_mem_rdata !== r1 || i_mem_ready !== 1'b0 || i_mem_rdata !== '0)
            begin errors++; $display("FAIL simul_d_done got dready=%b drdata=%h iready=%b irdata=%h exp 1 %h 0 0", d_mem_ready, d_mem_rdata, i_mem_ready, i_mem_rdata, r1); end
        @(negedge clk);
        set_d(0, 0, '0, '0);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b01 || mem_addr !== 28'h0000020)
            begin errors++; $display("FAIL simul_i_next got gnt=%b addr=%h exp 01 0000020", gnt, mem_addr); end
        @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = r2;
        #1;
        checks++;
        if (i_mem_ready !== 1'b1 || i_mem_rdata !== r2)
            begin errors++; $display("FAIL simul_i_done got ready=%b rdata=%h exp 1 %h", i_mem_ready, i_mem_rdata, r2); end
        @(negedge clk);
        set_i(0, 0, '0, '0);
        mem_ready = 1'b0;
    endtask

    task automatic test_writeback_refill();
        logic [127:0] wb;
        logic [1:0]   first_gnt, second_gnt;
        wb = {$urandom, $urandom, $urandom, $urandom};
        first_gnt  = RR ? 2'b01 : 2'b10;
        second_gnt = RR ? 2'b10 : 2'b01;
        @(negedge clk);
        set_d(0, 1, 28'h00000A3, wb);
        #1;
        checks++;
        if (gnt !== 2'b10 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 28'h00000A3 || mem_wdata !== wb)
            begin errors++; $display("FAIL wb_fwd got gnt=%b w=%b r=%b addr=%h wdata=%h exp 10 1 0 00000a3 %h", gnt, mem_write, mem_read, mem_addr, mem_wdata, wb); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (d_mem_ready !== 1'b1)
            begin errors++; $display("FAIL wb_done got ready=%b exp 1", d_mem_ready); end
        @(negedge clk);
        mem_ready = 1'b0;
        set_d(1, 0, 28'h00000A3, '0);
        set_i(1, 0, 28'h0000040, '0);
        #1;
        checks++;
        if (gnt !== first_gnt)
            begin errors++; $display("FAIL refill_winner got gnt=%b exp %b", gnt, first_gnt); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({d_mem_ready, i_mem_ready} !== first_gnt)
            begin errors++; $display("FAIL refill_first_done got d/i ready=%b%b exp %b", d_mem_ready, i_mem_ready, first_gnt); end
        @(negedge clk);
        mem_ready = 1'b0;
        if (first_gnt == 2'b10) set_d(0, 0, '0, '0); else set_i(0, 0, '0, '0);
        #1;
        checks++;
        if (gnt !== second_gnt)
            begin errors++; $display("FAIL refill_second got gnt=%b exp %b", gnt, second_gnt); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({d_mem_ready, i_mem_ready} !== second_gnt)
            begin errors++; $display("FAIL refill_second_done got d/i ready=%b%b exp %b", d_mem_ready, i_mem_ready, second_gnt); end
        @(negedge clk);
        set_i(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        mem_ready = 1'b0;
    endtask

    task automatic test_owner_drop();
        @(negedge clk);
        set_d(1, 0, 28'h0000055, '0);
        #1;
        checks++;
        if (gnt !== 2'b10 || mem_read !== 1'b1)
            begin errors++; $display("FAIL drop_grant got gnt=%b read=%b exp 10 1", gnt, mem_read); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            set_d(0, 0, 28'h0000055, '0);
            set_i(1, 0, 28'h0000066, '0);
            #1;
            checks++;
            if (gnt !== 2'b10 || mem_read !== 1'b0 || i_mem_ready !== 1'b0)
                begin errors++; $display("FAIL drop_hold%0d got gnt=%b read=%b iready=%b exp 10 0 0", k, gnt, mem_read, i_mem_ready); end
        end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b10 || d_mem_ready !== 1'b1 || i_mem_ready !== 1'b0)
            begin errors++; $display("FAIL drop_done got gnt=%b dready=%b iready=%b exp 10 1 0", gnt, d_mem_ready, i_mem_ready); end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b01 || mem_addr !== 28'h0000066)
            begin errors++; $display("FAIL drop_i_next got gnt=%b addr=%h exp 01 0000066", gnt, mem_addr); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        @(negedge clk);
        set_i(0, 0, '0, '0);
        mem_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        set_i(1, 0, 28'h0000088, '0);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (gnt !== 2'b01)
            begin errors++; $display("FAIL areset_pre got gnt=%b exp 01", gnt); end
        #1;
        rst_n = 1'b0;
        set_d(1, 0, 28'h0000099, '0);
        mem_ready = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b00 || mem_read !== 1'b0 || mem_addr !== '0 || i_mem_ready !== 1'b0 || d_mem_ready !== 1'b0)
            begin errors++; $display("FAIL areset_quiet got gnt=%b read=%b addr=%h ir=%b dr=%b exp 00 0 0 0 0", gnt, mem_read, mem_addr, i_mem_ready, d_mem_ready); end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b10 || mem_addr !== 28'h0000099)
            begin errors++; $display("FAIL areset_rearb got gnt=%b addr=%h exp 10 0000099", gnt, mem_addr); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        @(negedge clk);
        set_d(0, 0, '0, '0);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b01)
            begin errors++; $display("FAIL areset_i_after got gnt=%b exp 01", gnt); end
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        @(negedge clk);
        set_i(0, 0, '0, '0);
        mem_ready = 1'b0;
    endtask

    task automatic test_random();
        int           own, prev_own;
        bit           prev_rdy, ia, da, iw, dw, e_ir, e_dr;
        logic         e_rd, e_wr;
        logic [27:0]  e_addr;
        logic [127:0] e_wdata;
        @(negedge clk);
        set_i(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        mem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_busy = 0;
        m_last_d = 1'b0;
        prev_own = 0; prev_rdy = 1'b0;
        ia = 1'b0; da = 1'b0; iw = 1'b0; dw = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (prev_own != 0) begin
                if (prev_rdy) begin
                    m_busy = 0;
                    m_last_d = (prev_own == 2);
                    if (prev_own == 1) ia = 1'b0; else da = 1'b0;
                end else begin
                    m_busy = prev_own;
                end
            end
            if (ia && $urandom_range(15) == 0) ia = 1'b0;
            if (da && $urandom_range(15) == 0) da = 1'b0;
            if (!ia && $urandom_range(2) == 0) begin
                ia = 1'b1; iw = ($urandom_range(7) == 0);
                i_mem_addr = 28'($urandom); i_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!da && $urandom_range(2) == 0) begin
                da = 1'b1; dw = ($urandom_range(2) == 0);
                d_mem_addr = 28'($urandom); d_mem_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            i_mem_read = ia & ~iw; i_mem_write = ia & iw;
            d_mem_read = da & ~dw; d_mem_write = da & dw;
            mem_ready = ($urandom_range(3) == 0);
            mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            #1;
            own = pick_owner(ia, da);
            e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
            if (own == 1) begin e_rd = i_mem_read; e_wr = i_mem_write; e_addr = i_mem_addr; e_wdata = i_mem_wdata; end
            if (own == 2) begin e_rd = d_mem_read; e_wr = d_mem_write; e_addr = d_mem_addr; e_wdata = d_mem_wdata; end
            e_ir = (own == 1) && mem_ready;
            e_dr = (own == 2) && mem_ready;
            checks++;
            if (gnt !== 2'(own) || mem_read !== e_rd || mem_write !== e_wr || mem_addr !== e_addr || mem_wdata !== e_wdata)
                begin errors++; $display("FAIL rand_mem cyc%0d got gnt=%b r=%b w=%b addr=%h exp gnt=%0d r=%b w=%b addr=%h", n, gnt, mem_read, mem_write, mem_addr, own, e_rd, e_wr, e_addr); end
            checks++;
            if (i_mem_ready !== e_ir || (own != 1 && i_mem_rdata !== '0) || (e_ir && i_mem_rdata !== mem_rdata))
                begin errors++; $display("FAIL rand_i cyc%0d got ready=%b rdata=%h exp ready=%b owner=%0d", n, i_mem_ready, i_mem_rdata, e_ir, own); end
            checks++;
            if (d_mem_ready !== e_dr || (own != 2 && d_mem_rdata !== '0) || (e_dr && d_mem_rdata !== mem_rdata))
                begin errors++; $display("FAIL rand_d cyc%0d got ready=%b rdata=%h exp ready=%b owner=%0d", n, d_mem_ready, d_mem_rdata, e_dr, own); end
            prev_own = own;
            prev_rdy = mem_ready;
        end
        @(negedge clk);
        set_i(0, 0, '0, '0);
        set_d(0, 0, '0, '0);
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_simultaneous();
        test_writeback_refill();
        test_owner_drop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
